// File: rtl/pc_next_unit.sv
// Program counter / next-PC stage: resolves branches and jumps from ALU flags,
// registers the fetch PC, traps on misaligned targets and counts retirements.
module pc_next_unit #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            instr_valid,
  input  logic            stall,
  input  logic [2:0]      branch_type,
  input  logic [XLEN-1:0] imm,
  input  logic            alu_zero,
  input  logic            alu_less,
  input  logic [XLEN-1:0] alu_out,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            taken,
  output logic            trap,
  output logic [XLEN-1:0] trap_pc,
  output logic [63:0]     instret
);

  localparam logic [2:0] BR_BEQ  = 3'b001;
  localparam logic [2:0] BR_BNE  = 3'b010;
  localparam logic [2:0] BR_BLT  = 3'b011;
  localparam logic [2:0] BR_BGE  = 3'b100;
  localparam logic [2:0] BR_JAL  = 3'b101;
  localparam logic [2:0] BR_JALR = 3'b110;

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            trap_q, trap_d;
  logic [XLEN-1:0] trap_pc_q, trap_pc_d;
  logic [63:0]     instret_q, instret_d;

  logic [XLEN-1:0] target;
  logic            misaligned;
  logic            advance;

  // Datapath: flags -> taken mux -> target select, all in the ALU's cycle.
  always_comb begin
    pc_plus4 = pc_q + XLEN'(4);
    target   = pc_q + imm;
    taken    = 1'b0;
    case (branch_type)
      BR_BEQ:  taken = alu_zero;
      BR_BNE:  taken = !alu_zero;
      BR_BLT:  taken = alu_less;
      BR_BGE:  taken = !alu_less;
      BR_JAL:  taken = 1'b1;
      BR_JALR: begin
        taken  = 1'b1;
        target = alu_out & {{(XLEN-1){1'b1}}, 1'b0};
      end
      default: taken = 1'b0;
    endcase
    misaligned = taken && (target[1:0] != 2'b00);
    advance    = (state_q == RUN) && instr_valid && !stall;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      pc_q      <= RESET_PC;
      trap_q    <= 1'b0;
      trap_pc_q <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      trap_q    <= trap_d;
      trap_pc_q <= trap_pc_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (advance && misaligned) state_d = HALT;
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  // HALT freezes everything; only reset gets out.
  always_comb begin
    pc_d      = pc_q;
    trap_d    = trap_q;
    trap_pc_d = trap_pc_q;
    instret_d = instret_q;
    if (advance) begin
      if (misaligned) begin
        trap_d    = 1'b1;
        trap_pc_d = pc_q;
      end else begin
        pc_d      = taken ? target : pc_plus4;
        instret_d = instret_q + 64'd1;
      end
    end
  end

  assign pc      = pc_q;
  assign trap    = trap_q;
  assign trap_pc = trap_pc_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed-vector bench for pc_next_unit with hand-computed expectations.
module tb_pc_next_unit;

  logic        clk = 1'b0;
  logic        reset, instr_valid, stall, alu_zero, alu_less;
  logic [2:0]  branch_type;
  logic [63:0] imm, alu_out;
  logic [63:0] pc, pc_plus4, trap_pc, instret;
  logic        taken, trap;

  int total = 0;
  int bad   = 0;

  pc_next_unit #(.XLEN(64), .RESET_PC(64'h1000)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .stall(stall),
    .branch_type(branch_type), .imm(imm), .alu_zero(alu_zero),
    .alu_less(alu_less), .alu_out(alu_out), .pc(pc), .pc_plus4(pc_plus4),
    .taken(taken), .trap(trap), .trap_pc(trap_pc), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] bt, input logic [63:0] im, input logic z,
                       input logic l, input logic [63:0] ao);
    branch_type = bt; imm = im; alu_zero = z; alu_less = l; alu_out = ao;
  endtask

  task automatic jump_to(input logic [63:0] addr);
    drive(3'b110, 64'h0, 1'b0, 1'b0, addr);
    step();
  endtask

  initial begin
    reset = 1'b1; instr_valid = 1'b0; stall = 1'b0;
    drive(3'b000, 64'h0, 1'b0, 1'b0, 64'h0);
    step(); step();
    chk("rst_pc", pc, 64'h1000);
    chk("rst_trap", {63'h0, trap}, 64'h0);
    chk("rst_trap_pc", trap_pc, 64'h0);
    chk("rst_instret", instret, 64'h0);

    reset = 1'b0; instr_valid = 1'b1;
    step(); chk("seq1", pc, 64'h1004);
    step(); chk("seq2", pc, 64'h1008);
    step(); chk("seq3", pc, 64'h100C);
    chk("seq_instret", instret, 64'd3);
    chk("seq_trap", {63'h0, trap}, 64'h0);

    jump_to(64'h100);
    chk("jmp100", pc, 64'h100);
    drive(3'b001, -64'sd8, 1'b1, 1'b0, 64'h0);
    #1 chk("beq_taken", {63'h0, taken}, 64'h1);
    step(); chk("beq_pc", pc, 64'hF8);

    jump_to(64'h100);
    drive(3'b010, 64'h40, 1'b1, 1'b0, 64'h0);
    #1 chk("bne_taken", {63'h0, taken}, 64'h0);
    step(); chk("bne_pc", pc, 64'h104);

    jump_to(64'h100);
    drive(3'b100, 64'h20, 1'b0, 1'b0, 64'h0);
    step(); chk("bge_pc", pc, 64'h120);
    drive(3'b011, 64'h10, 1'b0, 1'b1, 64'h0);
    step(); chk("blt_pc", pc, 64'h130);
    drive(3'b111, 64'h10, 1'b1, 1'b1, 64'h0);
    #1 chk("rsv_taken", {63'h0, taken}, 64'h0);
    step(); chk("rsv_pc", pc, 64'h134);
    chk("br_instret", instret, 64'd11);

    jump_to(64'h200);
    drive(3'b101, 64'h40, 1'b0, 1'b0, 64'h0);
    #1 chk("jal_link", pc_plus4, 64'h204);
    chk("jal_taken", {63'h0, taken}, 64'h1);
    step(); chk("jal_pc", pc, 64'h240);
    drive(3'b110, 64'h0, 1'b0, 1'b0, 64'h3005);
    step(); chk("jalr_pc", pc, 64'h3004);

    jump_to(64'h500);
    chk("stall_pre_instret", instret, 64'd15);
    drive(3'b001, 64'h40, 1'b1, 1'b0, 64'h0);
    stall = 1'b1;
    step(); chk("stall1_pc", pc, 64'h500);
    step(); chk("stall2_pc", pc, 64'h500);
    stall = 1'b0; instr_valid = 1'b0;
    step(); chk("inv_pc", pc, 64'h500);
    chk("stall_instret", instret, 64'd15);
    instr_valid = 1'b1;
    step(); chk("resume_pc", pc, 64'h540);
    chk("resume_instret", instret, 64'd16);

    jump_to(64'h600);
    drive(3'b110, 64'h0, 1'b0, 1'b0, 64'h702);
    #1 chk("mis_taken", {63'h0, taken}, 64'h1);
    step();
    chk("trap_set", {63'h0, trap}, 64'h1);
    chk("trap_pc", trap_pc, 64'h600);
    chk("trap_hold_pc", pc, 64'h600);
    chk("trap_instret", instret, 64'd17);
    drive(3'b000, 64'h0, 1'b0, 1'b0, 64'h0);
    step(); step();
    chk("halt_pc", pc, 64'h600);
    chk("halt_instret", instret, 64'd17);
    chk("halt_trap", {63'h0, trap}, 64'h1);
    reset = 1'b1; stall = 1'b1;
    step();
    chk("rst_halt_trap", {63'h0, trap}, 64'h0);
    chk("rst_halt_pc", pc, 64'h1000);
    chk("rst_halt_tpc", trap_pc, 64'h0);
    chk("rst_halt_instret", instret, 64'h0);
    reset = 1'b0; stall = 1'b0;
    step(); chk("post_rst_pc", pc, 64'h1004);

    jump_to(64'hFFFF_FFFF_FFFF_FFFC);
    chk("top_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
    drive(3'b000, 64'h0, 1'b0, 1'b0, 64'h0);
    #1 chk("wrap_link", pc_plus4, 64'h0);
    step(); chk("wrap_pc", pc, 64'h0);
    chk("wrap_trap", {63'h0, trap}, 64'h0);

    instr_valid = 1'b0;
    @(negedge clk);
    force dut.instret_q = '1;
    #1 release dut.instret_q;
    chk("instret_preload", instret, 64'hFFFF_FFFF_FFFF_FFFF);
    instr_valid = 1'b1;
    step(); chk("instret_wrap", instret, 64'h0);
    chk("wrap_pc2", pc, 64'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_next_unit.md
# pc_next_unit

Program-counter and next-PC stage of the single-cycle processor, directly downstream of the ALU. It consumes the ALU's `zero`/`less` flags and result, resolves conditional branches and jumps, and registers the PC that addresses instruction memory in the next cycle. It also owns a misaligned-target trap with halt state and a retired-instruction counter.

## Interface
- `XLEN`, 64: datapath width.
- `RESET_PC`, 64'h0: PC value loaded on reset; must be 4-byte aligned.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `instr_valid` input 1: the instruction at `pc` is executing this cycle.
- `stall` input 1: hold the PC and counter this cycle.
- `branch_type` input 3: 000 none, 001 beq, 010 bne, 011 blt, 100 bge, 101 jal, 110 jalr, 111 reserved (treated as none).
- `imm` input XLEN: sign-extended byte offset from immediate generation, already shifted (bit 0 = 0).
- `alu_zero` input 1: ALU zero flag; valid only when the ALU runs SUB.
- `alu_less` input 1: ALU less flag, which is the SUB result sign bit.
- `alu_out` input XLEN: ALU result, used as the jalr target base.
- `pc` output XLEN: registered current PC.
- `pc_plus4` output XLEN: `pc + 4`, combinational; this is the link value for jal/jalr writeback.
- `taken` output 1: combinational; the control transfer is taken this cycle.
- `trap` output 1: registered; sticky misaligned-target flag.
- `trap_pc` output XLEN: registered; PC of the faulting instruction.
- `instret` output 64: registered count of retired instructions.

## Operation
- **Target:**
  - For beq/bne/blt/bge/jal the target is `pc + imm`.
  - For jalr the target is `alu_out & ~1`.
  - All arithmetic is modulo 2^XLEN.
- **Taken:**
  - beq: `alu_zero`.
  - bne: `!alu_zero`.
  - blt: `alu_less`.
  - bge: `!alu_less`.
  - jal and jalr: always taken.
  - none or reserved: never taken.
- The `alu_less` flag is used exactly as supplied. Signed-overflow correction is out of scope for this block.
- Control must program the ALU to SUB for beq, bne, blt and bge. If it does not, the flags read 0, so beq/blt fall through and bne/bge are taken.
- `advance = (state == RUN) && instr_valid && !stall`.
- **Misaligned:** `taken && target[1:0] != 2'b00`.
- **FSM, two states:**
  - RUN: if `advance` and not misaligned, `pc <= taken ? target : pc_plus4` and `instret` increments.
  - RUN: if `advance` and misaligned, go to HALT. Set `trap <= 1` and `trap_pc <= pc`. `pc` does not change and `instret` does not increment.
  - HALT: `pc`, `instret`, `trap` and `trap_pc` are frozen. Only `reset` leaves HALT, and it returns to RUN.
- `taken` and `pc_plus4` are driven combinationally in every state. They are informational in HALT.
- **Reset values:**
  - state = RUN
  - `pc` = RESET_PC
  - `trap` = 0
  - `trap_pc` = 0
  - `instret` = 0
- **Wrap-around:**
  - PC `0xFFFF_FFFF_FFFF_FFFC + 4` gives 0; no flag is raised.
  - `instret` wraps from all-ones to 0.

## Timing
- The PC update has one-cycle latency. A branch resolved in cycle N sets `pc` to the target at the edge ending cycle N.
- No handshake: `instr_valid` and `stall` are sampled at each rising edge.
- If `stall` and `instr_valid` are both 1, the stall wins: nothing updates.
- `instr_valid = 0` also holds all state.
- `reset` asserted in any state, including mid-stall and in HALT, overrides every other input at that edge.
- A trap is visible on `trap` in the cycle after the faulting edge.
- The `taken` path goes from the ALU flags through the taken mux into the PC register. It must close in one cycle together with the ALU.

## Test plan
- **Reset and sequential fetch:** assert `reset` for 2 cycles with RESET_PC = 0x1000, then hold `instr_valid = 1` and `branch_type = 000` for 3 cycles.
  - Expect `pc` = 0x1000, then 0x1004, 0x1008, 0x100C.
  - Expect `instret` = 3 and `trap` = 0.
- **Conditional branches:** start from `pc` = 0x100.
  - beq with `imm` = -8 and `alu_zero` = 1: expect `taken` = 1 and next `pc` = 0xF8.
  - bne with `alu_zero` = 1: expect `taken` = 0 and next `pc` = 0x104.
  - bge with `alu_less` = 0 and `imm` = 0x20: expect next `pc` = 0x120.
- **Jumps:** start from `pc` = 0x200.
  - jal with `imm` = 0x40: expect `pc_plus4` = 0x204 and next `pc` = 0x240.
  - jalr with `alu_out` = 0x3005: expect next `pc` = 0x3004.
- **Stall and invalid:** at `pc` = 0x500 with beq taken, assert `stall` = 1 for 2 cycles, then `instr_valid` = 0 for 1 cycle.
  - Expect `pc` to stay 0x500 and `instret` to stay unchanged.
  - After `stall` and `instr_valid` are released, expect the branch to be taken on the next edge.
- **Misaligned trap:** at `pc` = 0x600, jalr with `alu_out` = 0x702 (target 0x702).
  - Expect `trap` = 1, `trap_pc` = 0x600, `pc` held at 0x600 and `instret` unchanged.
  - Further valid instructions must not move the PC.
  - Asserting `reset` clears `trap` and restores RESET_PC.
- **Wrap:** from `pc` = 0xFFFF_FFFF_FFFF_FFFC with sequential execution, expect next `pc` = 0. Preload `instret` to all-ones via a long run (or force), then check it wraps to 0.
